// File: rtl/window_apb_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : window_apb_loader_if
// Brief    : APB bus bundle between the window loader (master) and window_func.
// Revision : 1.0
// ============================================================================
interface window_apb_loader_if #(
    parameter int APB_AW = 16
) ();
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [APB_AW-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;

    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface
`default_nettype wire

// File: rtl/window_apb_loader.sv
`default_nettype none
// ============================================================================
// Module   : window_apb_loader
// Brief    : Streams window coefficients from AXIS into window_func over APB,
//            sets packet mode and arms the block.
// Revision : 1.0
// ============================================================================
module window_apb_loader #(
    parameter int FFT_SIZE = 8192,
    parameter int APB_AW   = $clog2(FFT_SIZE-1)+2+1,
    parameter bit ONE_PACK = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    input  logic        in_tvalid,
    output logic        in_tready,
    input  logic        in_tlast,
    input  logic [31:0] in_tdata,
    window_apb_loader_if.master apb
);
    localparam int CW = $clog2(FFT_SIZE);
    localparam logic [APB_AW-1:0] c_ctrl1_addr = APB_AW'(FFT_SIZE*4);
    localparam logic [APB_AW-1:0] c_ctrl2_addr = APB_AW'((FFT_SIZE+1)*4);
    localparam logic [CW-1:0]     c_last       = CW'(FFT_SIZE-1);

    localparam logic [1:0] c_err_ok    = 2'd0;
    localparam logic [1:0] c_err_len   = 2'd1;
    localparam logic [1:0] c_err_state = 2'd2;
    localparam logic [1:0] c_err_abort = 2'd3;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_RST  = 4'd1;
    localparam logic [3:0] S_MODE = 4'd2;
    localparam logic [3:0] S_LOAD = 4'd3;
    localparam logic [3:0] S_CHK  = 4'd4;
    localparam logic [3:0] S_GO   = 4'd5;
    localparam logic [3:0] S_VFY  = 4'd6;
    localparam logic [3:0] S_ABT  = 4'd7;
    localparam logic [3:0] S_DONE = 4'd8;

    logic [3:0]        r_state, w_next;
    logic              r_psel, r_penable, r_pwrite;
    logic [APB_AW-1:0] r_paddr;
    logic [31:0]       r_pwdata;
    logic [31:0]       r_ctrl1;
    logic [CW-1:0]     r_count;
    logic              r_load_end, r_len_err, r_abort_pend;
    logic [1:0]        r_err;

    logic              w_xfer_done, w_in_seq, w_abort_req, w_last_beat, w_accept;
    logic              w_launch, w_lwr;
    logic [APB_AW-1:0] w_laddr;
    logic [31:0]       w_ldata;
    logic              w_err_set;
    logic [1:0]        w_err_val;
    logic [1:0]        w_rb_state;
    logic              w_unused_rd;

    assign w_xfer_done = r_psel & r_penable;
    assign w_in_seq    = (r_state == S_RST) || (r_state == S_MODE) || (r_state == S_LOAD) ||
                         (r_state == S_CHK) || (r_state == S_GO)   || (r_state == S_VFY);
    assign w_abort_req = w_in_seq & (abort | r_abort_pend);
    assign w_last_beat = (r_count == c_last);
    assign w_rb_state  = apb.prdata[9:8];
    assign w_unused_rd = ^{apb.prdata[31:10], apb.prdata[7:0]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Abort only diverts the sequence at a transfer boundary, never mid-ACCESS.
    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        w_err_val = c_err_ok;
        if (w_abort_req && (!r_psel || w_xfer_done)) begin
            w_next = S_ABT;
        end else begin
            case (r_state)
                S_IDLE: if (start) w_next = S_RST;
                S_RST:  if (w_xfer_done) w_next = S_MODE;
                S_MODE: if (w_xfer_done) w_next = S_LOAD;
                S_LOAD: if (w_xfer_done && r_load_end) begin
                    if (r_len_err) begin
                        w_next    = S_DONE;
                        w_err_set = 1'b1;
                        w_err_val = c_err_len;
                    end else begin
                        w_next = S_CHK;
                    end
                end
                S_CHK:  if (w_xfer_done) begin
                    if (w_rb_state == 2'b00) begin
                        w_next = S_GO;
                    end else begin
                        w_next    = S_DONE;
                        w_err_set = 1'b1;
                        w_err_val = c_err_state;
                    end
                end
                S_GO:   if (w_xfer_done) w_next = S_VFY;
                S_VFY:  if (w_xfer_done) begin
                    w_next = S_DONE;
                    if (w_rb_state != 2'b01) begin
                        w_err_set = 1'b1;
                        w_err_val = c_err_state;
                    end
                end
                S_ABT:  if (w_xfer_done) begin
                    w_next    = S_DONE;
                    w_err_set = 1'b1;
                    w_err_val = c_err_abort;
                end
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        // Ready during ACCESS lets the next SETUP follow immediately (2 cycles/coeff).
        in_tready = (r_state == S_LOAD) & ~r_load_end & (~r_psel | r_penable) & ~w_abort_req;
        w_accept  = in_tready & in_tvalid;
        w_launch  = 1'b0;
        w_lwr     = 1'b1;
        w_laddr   = '0;
        w_ldata   = '0;
        case (r_state)
            S_RST, S_ABT: begin
                w_launch = ~r_psel & ~w_abort_req;
                w_laddr  = c_ctrl1_addr;
                w_ldata  = r_ctrl1 ^ 32'h0000_0001;
            end
            S_GO: begin
                w_launch = ~r_psel & ~w_abort_req;
                w_laddr  = c_ctrl1_addr;
                w_ldata  = r_ctrl1 ^ 32'h0000_0100;
            end
            S_MODE: begin
                w_launch = ~r_psel & ~w_abort_req;
                w_laddr  = c_ctrl2_addr;
                w_ldata  = {31'b0, ONE_PACK};
            end
            S_CHK, S_VFY: begin
                w_launch = ~r_psel & ~w_abort_req;
                w_lwr    = 1'b0;
                w_laddr  = c_ctrl2_addr;
            end
            S_LOAD: begin
                w_launch = w_accept;
                w_laddr  = APB_AW'({r_count, 2'b00});
                w_ldata  = in_tdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_ctrl1      <= '0;
            r_count      <= '0;
            r_load_end   <= 1'b0;
            r_len_err    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_err        <= c_err_ok;
        end else begin
            if (w_launch) begin
                r_psel    <= 1'b1;
                r_penable <= 1'b0;
                r_pwrite  <= w_lwr;
                r_paddr   <= w_laddr;
                r_pwdata  <= w_ldata;
            end else if (r_psel && !r_penable) begin
                r_penable <= 1'b1;
            end else if (w_xfer_done) begin
                r_psel    <= 1'b0;
                r_penable <= 1'b0;
            end

            if (w_launch && (r_state == S_RST || r_state == S_GO || r_state == S_ABT))
                r_ctrl1 <= w_ldata;

            if (r_state == S_IDLE && start) begin
                r_err      <= c_err_ok;
                r_count    <= '0;
                r_load_end <= 1'b0;
                r_len_err  <= 1'b0;
            end else if (w_err_set) begin
                r_err <= w_err_val;
            end

            // Final or mis-flagged beat is still written, but closes the stream.
            if (w_accept) begin
                if (w_last_beat || in_tlast) begin
                    r_load_end <= 1'b1;
                    r_len_err  <= (in_tlast != w_last_beat);
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end

            if (!w_in_seq)  r_abort_pend <= 1'b0;
            else if (abort) r_abort_pend <= 1'b1;
        end
    end

    assign err_code    = r_err;
    assign apb.psel    = r_psel;
    assign apb.penable = r_penable;
    assign apb.pwrite  = r_pwrite;
    assign apb.paddr   = r_paddr;
    assign apb.pwdata  = r_pwdata;
endmodule
`default_nettype wire

// File: tb/tb_window_apb_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_apb_loader
// Brief    : Drives the loader against a behavioural window_func target model.
// Revision : 1.0
// ============================================================================
module tb_window_apb_loader;
    localparam int FFT = 8;
    localparam int AW  = $clog2(FFT-1)+2+1;
    localparam logic [AW-1:0] C1 = AW'(FFT*4);
    localparam logic [AW-1:0] C2 = AW'((FFT+1)*4);

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } xfer_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, sel1 = 1'b0;
    logic in_tvalid = 1'b0, in_tlast = 1'b0;
    logic [31:0] in_tdata = '0;
    logic busy0, busy1, done0, done1, rdy0, rdy1;
    logic [1:0] err0, err1;

    window_apb_loader_if #(.APB_AW(AW)) bus0 ();
    window_apb_loader_if #(.APB_AW(AW)) bus1 ();

    window_apb_loader #(.FFT_SIZE(FFT), .APB_AW(AW), .ONE_PACK(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start & ~sel1), .abort(abort),
        .busy(busy0), .done(done0), .err_code(err0),
        .in_tvalid(in_tvalid & ~sel1), .in_tready(rdy0), .in_tlast(in_tlast), .in_tdata(in_tdata),
        .apb(bus0));

    window_apb_loader #(.FFT_SIZE(FFT), .APB_AW(AW), .ONE_PACK(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start & sel1), .abort(abort),
        .busy(busy1), .done(done1), .err_code(err1),
        .in_tvalid(in_tvalid & sel1), .in_tready(rdy1), .in_tlast(in_tlast), .in_tdata(in_tdata),
        .apb(bus1));

    always #5 clk = ~clk;

    logic m_psel, m_pen, m_pwrite, m_busy, m_done, m_rdy;
    logic [AW-1:0] m_paddr;
    logic [31:0] m_pwdata;
    logic [1:0] m_err;
    assign m_psel   = sel1 ? bus1.psel    : bus0.psel;
    assign m_pen    = sel1 ? bus1.penable : bus0.penable;
    assign m_pwrite = sel1 ? bus1.pwrite  : bus0.pwrite;
    assign m_paddr  = sel1 ? bus1.paddr   : bus0.paddr;
    assign m_pwdata = sel1 ? bus1.pwdata  : bus0.pwdata;
    assign m_busy   = sel1 ? busy1 : busy0;
    assign m_done   = sel1 ? done1 : done0;
    assign m_rdy    = sel1 ? rdy1  : rdy0;
    assign m_err    = sel1 ? err1  : err0;

    // Target: CTRL1 commands fire on bit changes; CTRL2 reports mode and state.
    logic [31:0] tgt_mem [FFT];
    logic [31:0] tgt_c1;
    logic [1:0]  tgt_state;
    logic        tgt_mode;
    logic        force_st = 1'b0;
    logic [31:0] stat_word;
    assign stat_word   = {22'b0, (force_st ? 2'b10 : tgt_state), 7'b0, tgt_mode};
    assign bus0.prdata = (bus0.paddr == C2) ? stat_word : 32'h0;
    assign bus1.prdata = (bus1.paddr == C2) ? stat_word : 32'h0;

    int n_vec = 0, n_err = 0;
    xfer_t got_q[$], exp_q[$];
    logic [31:0] exp_c1 = '0;
    logic [31:0] beat [FFT];
    logic drv_stop = 1'b0;

    logic          prev_psel, prev_pen, prev_wr;
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_wd;

    always @(negedge clk) begin
        if (rst) begin
            prev_psel = 1'b0; prev_pen = 1'b0;
            tgt_c1 = '0; tgt_state = 2'b00; tgt_mode = 1'b0;
        end else begin
            if (m_psel && m_pen) begin
                n_vec++;
                if (!(prev_psel && !prev_pen) || prev_addr !== m_paddr ||
                    prev_wr !== m_pwrite || prev_wd !== m_pwdata) begin
                    n_err++;
                    $display("FAIL apb_setup_access addr=%h: prev psel/penable=%b%b addr=%h wr=%b, required 10 with stable fields",
                             m_paddr, prev_psel, prev_pen, prev_addr, prev_wr);
                end
                got_q.push_back('{wr: m_pwrite, addr: m_paddr, data: (m_pwrite ? m_pwdata : 32'h0)});
                if (m_pwrite) begin
                    if (m_paddr < C1) begin
                        tgt_mem[int'(m_paddr) / 4] = m_pwdata;
                    end else if (m_paddr == C1) begin
                        if (m_pwdata[0] !== tgt_c1[0]) tgt_state = 2'b00;
                        if (m_pwdata[8] !== tgt_c1[8]) tgt_state = 2'b01;
                        tgt_c1 = m_pwdata;
                    end else if (m_paddr == C2) begin
                        tgt_mode = m_pwdata[0];
                    end
                end
            end
            prev_psel = m_psel; prev_pen = m_pen; prev_wr = m_pwrite;
            prev_addr = m_paddr; prev_wd = m_pwdata;
        end
    end

    // Reference model: the transfer list each sequence must produce.
    task automatic exp_w(input logic [AW-1:0] a, input logic [31:0] d);
        exp_q.push_back('{wr: 1'b1, addr: a, data: d});
    endtask
    task automatic exp_r();
        exp_q.push_back('{wr: 1'b0, addr: C2, data: 32'h0});
    endtask
    task automatic exp_toggle(input int b);
        exp_c1[b] = ~exp_c1[b];
        exp_w(C1, exp_c1);
    endtask
    task automatic exp_prologue(input logic mode);
        exp_q.delete();
        exp_toggle(0);
        exp_w(C2, {31'b0, mode});
    endtask
    task automatic exp_coeffs(input int n);
        for (int k = 0; k < n; k++) exp_w(AW'(k*4), beat[k]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_c1 = '0;
    endtask

    task automatic drive_beats(input int nb, input int last_at, input int duty);
        int k;
        k = 0;
        while (k < nb && !drv_stop) begin
            in_tvalid = ($urandom_range(0, 99) < duty);
            in_tdata  = beat[k];
            in_tlast  = (k == last_at);
            @(negedge clk);
            if (in_tvalid && m_rdy) k++;
            @(posedge clk); #1;
        end
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic run_seq(input int nb, input int last_at, input int duty, input int abort_at,
                           output bit seen, output logic b_at, output logic d_after, output logic b_after);
        got_q.delete();
        drv_stop = 1'b0; seen = 1'b0; b_at = 1'b0; d_after = 1'b1; b_after = 1'b1;
        pulse_start();
        fork
            drive_beats(nb, last_at, duty);
            begin : g_wait
                for (int i = 0; i < 400 && !seen; i++) begin
                    @(negedge clk);
                    if (m_done) begin seen = 1'b1; b_at = m_busy; end
                end
                drv_stop = 1'b1;
            end
            begin : g_abort
                if (abort_at >= 0) begin
                    for (int i = 0; i < 400; i++) begin
                        @(negedge clk);
                        if (m_psel && m_pen && m_pwrite && m_paddr == AW'(abort_at*4)) begin
                            abort = 1'b1;
                            break;
                        end
                    end
                    @(posedge clk); #1 abort = 1'b0;
                end
            end
        join
        if (seen) begin
            @(negedge clk);
            d_after = m_done; b_after = m_busy;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_vec++;
        if ({bus0.psel, bus0.penable, bus0.pwrite, bus0.paddr, bus0.pwdata, busy0, done0, err0, rdy0} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_dut0 got psel=%b pen=%b busy=%b done=%b err=%0d rdy=%b, required all 0",
                     bus0.psel, bus0.penable, busy0, done0, err0, rdy0);
        end
        n_vec++;
        if ({bus1.psel, bus1.penable, bus1.pwrite, bus1.paddr, bus1.pwdata, busy1, done1, err1, rdy1} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs_dut1 got psel=%b pen=%b busy=%b done=%b err=%0d rdy=%b, required all 0",
                     bus1.psel, bus1.penable, busy1, done1, err1, rdy1);
        end
    endtask

    task automatic test_full_load(input string name, input int duty, input logic mode, input bit rand_data);
        bit seen; logic b_at, d_after, b_after;
        for (int k = 0; k < FFT; k++) beat[k] = rand_data ? $urandom() : 32'h0001_0000 + k;
        exp_prologue(mode);
        exp_coeffs(FFT);
        exp_r();
        exp_toggle(8);
        exp_r();
        run_seq(FFT, FFT-1, duty, -1, seen, b_at, d_after, b_after);
        n_vec++;
        if (!seen || {b_at, d_after, b_after} !== 3'b100) begin
            n_err++;
            $display("FAIL %s_done seen=%b busy@done/done+1/busy+1=%b%b%b, required 1 and 100", name, seen, b_at, d_after, b_after);
        end
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s_xfer_count got %0d required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s_xfer%0d got wr=%b addr=%h data=%h required wr=%b addr=%h data=%h", name, i,
                         got_q[i].wr, got_q[i].addr, got_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
            end
        end
        for (int k = 0; k < FFT; k++) begin
            n_vec++;
            if (tgt_mem[k] !== beat[k]) begin
                n_err++;
                $display("FAIL %s_mem%0d got %h required %h", name, k, tgt_mem[k], beat[k]);
            end
        end
        n_vec++;
        if (m_err !== 2'd0) begin
            n_err++;
            $display("FAIL %s_err got %0d required 0", name, m_err);
        end
    endtask

    task automatic test_one_pack();
        do_reset();
        sel1 = 1'b1;
        test_full_load("onepack", 30, 1'b1, 1'b1);
        do_reset();
        sel1 = 1'b0;
    endtask

    task automatic test_early_tlast();
        bit seen; logic b_at, d_after, b_after;
        for (int k = 0; k < FFT; k++) beat[k] = $urandom();
        exp_prologue(1'b0);
        exp_coeffs(5);
        run_seq(FFT, 4, 100, -1, seen, b_at, d_after, b_after);
        n_vec++;
        if (!seen || {b_at, d_after, b_after} !== 3'b100) begin
            n_err++;
            $display("FAIL tlast_done seen=%b busy@done/done+1/busy+1=%b%b%b, required 1 and 100", seen, b_at, d_after, b_after);
        end
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL tlast_xfer_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL tlast_xfer%0d got wr=%b addr=%h data=%h required wr=%b addr=%h data=%h", i,
                         got_q[i].wr, got_q[i].addr, got_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
            end
        end
        n_vec++;
        if (m_err !== 2'd1) begin
            n_err++;
            $display("FAIL tlast_err got %0d required 1", m_err);
        end
        in_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++;
            if (m_rdy !== 1'b0) begin
                n_err++;
                $display("FAIL tlast_tready_after got %b required 0", m_rdy);
            end
        end
        in_tvalid = 1'b0;
    endtask

    task automatic test_abort();
        bit seen; logic b_at, d_after, b_after;
        for (int k = 0; k < FFT; k++) beat[k] = $urandom();
        exp_prologue(1'b0);
        exp_coeffs(4);
        exp_toggle(0);
        run_seq(FFT, FFT-1, 100, 3, seen, b_at, d_after, b_after);
        n_vec++;
        if (!seen || {b_at, d_after, b_after} !== 3'b100) begin
            n_err++;
            $display("FAIL abort_done seen=%b busy@done/done+1/busy+1=%b%b%b, required 1 and 100", seen, b_at, d_after, b_after);
        end
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL abort_xfer_count got %0d required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL abort_xfer%0d got wr=%b addr=%h data=%h required wr=%b addr=%h data=%h", i,
                         got_q[i].wr, got_q[i].addr, got_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
            end
        end
        n_vec++;
        if (m_err !== 2'd3) begin
            n_err++;
            $display("FAIL abort_err got %0d required 3", m_err);
        end
    endtask

    task automatic test_state_err_and_reset();
        bit seen; logic b_at, d_after, b_after;
        bit hit;
        for (int k = 0; k < FFT; k++) beat[k] = $urandom();
        exp_prologue(1'b0);
        exp_coeffs(FFT);
        exp_r();
        force_st = 1'b1;
        run_seq(FFT, FFT-1, 100, -1, seen, b_at, d_after, b_after);
        force_st = 1'b0;
        n_vec++;
        if (!seen || got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL staterr_xfer_count seen=%b got %0d required %0d", seen, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL staterr_xfer%0d got wr=%b addr=%h data=%h required wr=%b addr=%h data=%h", i,
                         got_q[i].wr, got_q[i].addr, got_q[i].data, exp_q[i].wr, exp_q[i].addr, exp_q[i].data);
            end
        end
        n_vec++;
        if (m_err !== 2'd2) begin
            n_err++;
            $display("FAIL staterr_err got %0d required 2", m_err);
        end

        drv_stop = 1'b0;
        hit = 1'b0;
        pulse_start();
        fork
            drive_beats(FFT, FFT-1, 100);
            begin : g_rst
                for (int i = 0; i < 200 && !hit; i++) begin
                    @(negedge clk);
                    if (m_psel && m_paddr == AW'(8)) hit = 1'b1;
                end
                rst = 1'b1;
                @(posedge clk); #1;
                n_vec++;
                if (!hit || {m_psel, m_busy, m_err, m_rdy} !== 5'b0) begin
                    n_err++;
                    $display("FAIL midload_reset hit=%b got psel=%b busy=%b err=%0d rdy=%b, required all 0",
                             hit, m_psel, m_busy, m_err, m_rdy);
                end
                drv_stop = 1'b1;
            end
        join
        @(posedge clk); #1 rst = 1'b0;
        exp_c1 = '0;
    endtask

    initial begin
        test_reset();
        test_full_load("basic", 100, 1'b0, 1'b0);
        test_full_load("second", 100, 1'b0, 1'b0);
        test_early_tlast();
        test_one_pack();
        test_abort();
        test_state_err_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
